mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares the single memory port between two requesters. Requester 0 is the CPU data path, driven by the control unit's READ/WRITE. Requester 1 is the program-loader/DMA port.
- Owns the memory strobes, address and write-data bus, and sequences each access over a fixed memory latency.
- Returns read data and a one-cycle ACK to the winning requester.
- Sits between the processor top level and the memory model.

Parameters:
- ADDR_WIDTH, 26, width of memory address.
- DATA_WIDTH, 32, width of memory data words.
- MEM_LATENCY, 2, number of cycles the memory strobe is held per access. Legal values are 1 to 15.
- FIXED_PRIO, 0. 0 selects round-robin on a tie. 1 means requester 0 always wins a tie.

Ports:
- CLK  input  1  system clock; all logic on the rising edge.
- RST  input  1  reset, synchronous, active-high.
- REQ0  input  1  requester 0 access request, level.
- WR0  input  1  requester 0 direction; 1 = write, 0 = read.
- ADDR0  input  ADDR_WIDTH  requester 0 address.
- WDATA0  input  DATA_WIDTH  requester 0 write data.
- ACK0  output  1  requester 0 completion pulse.
- REQ1  input  1  requester 1 access request, level.
- WR1  input  1  requester 1 direction.
- ADDR1  input  ADDR_WIDTH  requester 1 address.
- WDATA1  input  DATA_WIDTH  requester 1 write data.
- ACK1  output  1  requester 1 completion pulse.
- RDATA  output  DATA_WIDTH  read data; valid while the corresponding ACK is high.
- MEM_READ  output  1  memory read strobe.
- MEM_WRITE  output  1  memory write strobe.
- MEM_ADDR  output  ADDR_WIDTH  memory address.
- MEM_WDATA  output  DATA_WIDTH  memory write data.
- MEM_RDATA  input  DATA_WIDTH  memory read data.
- BUSY  output  1  high in any state other than IDLE.
- GNT_ID  output  1  index of the current or last granted requester.

Behaviour:
- Reset (RST high at a rising edge):
  - State goes to IDLE.
  - All outputs go to 0: ACK0/1, MEM_READ, MEM_WRITE, MEM_ADDR, MEM_WDATA, RDATA, BUSY, GNT_ID.
  - Latency counter is cleared.
  - LAST register is set to 1, so requester 0 wins the first tie.
  - Reset overrides every other event.
  - A transaction in flight is aborted: no ACK is issued and the strobes drop on the next cycle.
- State machine, IDLE:
  - If neither REQ is high, remain in IDLE.
  - If one REQ is high, grant that requester.
  - If both REQ are high: with FIXED_PRIO=1, grant 0. With FIXED_PRIO=0, grant the requester not equal to LAST.
  - On grant, latch the winner's WR, ADDR and WDATA into MEM_* registers, set GNT_ID and LAST to the winner, load the counter with MEM_LATENCY-1, and go to ACCESS.
- State machine, ACCESS:
  - MEM_READ = ~WR_latched and MEM_WRITE = WR_latched, both high for every ACCESS cycle.
  - MEM_ADDR and MEM_WDATA are held constant.
  - Counter decrements each cycle.
  - In the cycle the counter equals 0: if the access is a read, capture MEM_RDATA into RDATA at the closing edge; then go to RESP.
- State machine, RESP:
  - Strobes are low.
  - ACK[GNT_ID] is high for exactly this one cycle.
  - RDATA holds the captured value. It is unchanged for writes.
  - Next state is IDLE.
- Timing: REQ sampled at edge E0. Strobes are high in cycles 1..MEM_LATENCY. ACK is high in cycle MEM_LATENCY+1. The next grant is sampled at the end of the following IDLE cycle. One access completes every MEM_LATENCY+2 cycles.
- Handshake rules:
  - Requester holds REQ, WR, ADDR and WDATA stable until it samples ACK high.
  - Requester deasserts REQ at that same edge, so the IDLE cycle after RESP sees REQ low.
  - A REQ still high in IDLE is treated as a new request.
  - Arbiter inputs of the non-granted requester are ignored until IDLE.
  - A REQ that drops before ACK is unsupported. The arbiter still completes the access and pulses ACK.
- Round-robin and LAST:
  - LAST updates only on grant.
  - A lone requester may be granted back to back indefinitely.
  - Under continuous dual requests with FIXED_PRIO=0, grants strictly alternate 0,1,0,1.
- Width rules: no arithmetic on data. Counter width is 4 bits.
- MEM_ADDR/MEM_WDATA retain their last values in IDLE and RESP. They do not return to 0 except on reset.

Test Plan:
- Reset then single read: REQ0=1, WR0=0, ADDR0=26'h0000100, memory returns 32'hDEADBEEF, MEM_LATENCY=2.
  - MEM_READ high for 2 cycles with MEM_ADDR=26'h0000100.
  - ACK0 pulses 1 cycle in cycle 3 with RDATA=32'hDEADBEEF.
  - ACK1 stays 0.
- Single write from requester 1: REQ1=1, WR1=1, ADDR1=26'h0000004, WDATA1=32'h12345678.
  - MEM_WRITE high 2 cycles with MEM_WDATA=32'h12345678 and MEM_READ=0.
  - ACK1 pulses once and GNT_ID=1.
  - RDATA keeps its prior value.
- Simultaneous requests, FIXED_PRIO=0, both REQ held high for 4 transactions: grant order is 0,1,0,1 with ACK pulses 4 cycles apart.
- Simultaneous requests, FIXED_PRIO=1: both REQ held for 3 transactions, with requester 0 re-requesting each time.
  - Three ACK0 pulses; requester 1 is never granted.
  - After REQ0 drops, requester 1 is granted in the next IDLE.
- Reset mid-operation: assert RST in the first ACCESS cycle of a read.
  - Next cycle: MEM_READ=0, BUSY=0 and state IDLE.
  - No ACK0 follows.
  - A subsequent tie is granted to requester 0.
- MEM_LATENCY=1 boundary: a read takes 1 strobe cycle, ACK in cycle 2, and back-to-back requests complete every 3 cycles.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for a single memory port: picks a winner in IDLE,
// holds the strobes for MEM_LATENCY cycles, then pulses the winner's ACK.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH  = 26,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_LATENCY = 2,
    parameter int FIXED_PRIO  = 0
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  REQ0,
    input  logic                  WR0,
    input  logic [ADDR_WIDTH-1:0] ADDR0,
    input  logic [DATA_WIDTH-1:0] WDATA0,
    output logic                  ACK0,
    input  logic                  REQ1,
    input  logic                  WR1,
    input  logic [ADDR_WIDTH-1:0] ADDR1,
    input  logic [DATA_WIDTH-1:0] WDATA1,
    output logic                  ACK1,
    output logic [DATA_WIDTH-1:0] RDATA,
    output logic                  MEM_READ,
    output logic                  MEM_WRITE,
    output logic [ADDR_WIDTH-1:0] MEM_ADDR,
    output logic [DATA_WIDTH-1:0] MEM_WDATA,
    input  logic [DATA_WIDTH-1:0] MEM_RDATA,
    output logic                  BUSY,
    output logic                  GNT_ID
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(MEM_LATENCY - 1);

    state_t                state_reg;
    logic [3:0]            cnt_reg;
    logic                  last_reg;
    logic                  gnt_reg;
    logic                  wr_reg;
    logic                  ack0_reg;
    logic                  ack1_reg;
    logic                  mem_read_reg;
    logic                  mem_write_reg;
    logic                  busy_reg;
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [DATA_WIDTH-1:0] wdata_reg;
    logic [DATA_WIDTH-1:0] rdata_reg;

    logic                  grant_valid;
    logic                  winner;
    logic                  win_wr;
    logic [ADDR_WIDTH-1:0] win_addr;
    logic [DATA_WIDTH-1:0] win_wdata;

    // On a tie, round-robin favours whoever was not granted last.
    always_comb begin
        grant_valid = REQ0 | REQ1;
        winner      = 1'b0;
        if (REQ0 && REQ1) begin
            winner = (FIXED_PRIO != 0) ? 1'b0 : ~last_reg;
        end else if (REQ1) begin
            winner = 1'b1;
        end
        win_wr    = winner ? WR1    : WR0;
        win_addr  = winner ? ADDR1  : ADDR0;
        win_wdata = winner ? WDATA1 : WDATA0;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg     <= IDLE;
            cnt_reg       <= 4'd0;
            last_reg      <= 1'b1;
            gnt_reg       <= 1'b0;
            wr_reg        <= 1'b0;
            ack0_reg      <= 1'b0;
            ack1_reg      <= 1'b0;
            mem_read_reg  <= 1'b0;
            mem_write_reg <= 1'b0;
            busy_reg      <= 1'b0;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            rdata_reg     <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (grant_valid) begin
                        state_reg     <= ACCESS;
                        wr_reg        <= win_wr;
                        addr_reg      <= win_addr;
                        wdata_reg     <= win_wdata;
                        gnt_reg       <= winner;
                        last_reg      <= winner;
                        cnt_reg       <= CNT_LOAD;
                        mem_read_reg  <= ~win_wr;
                        mem_write_reg <= win_wr;
                        busy_reg      <= 1'b1;
                    end
                end
                ACCESS: begin
                    if (cnt_reg == 4'd0) begin
                        // Final strobe cycle: memory data is valid at this edge.
                        if (!wr_reg) begin
                            rdata_reg <= MEM_RDATA;
                        end
                        mem_read_reg  <= 1'b0;
                        mem_write_reg <= 1'b0;
                        ack0_reg      <= ~gnt_reg;
                        ack1_reg      <= gnt_reg;
                        state_reg     <= RESP;
                    end else begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end
                end
                RESP: begin
                    ack0_reg  <= 1'b0;
                    ack1_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign ACK0      = ack0_reg;
    assign ACK1      = ack1_reg;
    assign RDATA     = rdata_reg;
    assign MEM_READ  = mem_read_reg;
    assign MEM_WRITE = mem_write_reg;
    assign MEM_ADDR  = addr_reg;
    assign MEM_WDATA = wdata_reg;
    assign BUSY      = busy_reg;
    assign GNT_ID    = gnt_reg;

endmodule
